// File: rtl/completion_arbiter.sv
// completion_arbiter: merges out-of-order completions from NUM_REQ functional
// units onto one registered completion bus through per-unit one-entry buffers.
// Ports: clk_i/reset_i (sync, active-high), flush_i, per-requester
// valid/ready/data/flags/tag/save_cond, registered data_o/flags_o/tag_o/save_cond_o,
// and combinational grant_o.
// Macro COMPLETION_ARB_RR_EN: defined selects round-robin arbitration; otherwise
// fixed priority (lowest index wins).
module completion_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ROBsize    = 32,
  parameter int ROBsizeLog = $clog2(ROBsize + 1)
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           flush_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ*64-1:0]          req_data_i,
  input  logic [NUM_REQ*4-1:0]           req_flags_i,
  input  logic [NUM_REQ*ROBsizeLog-1:0]  req_tag_i,
  input  logic [NUM_REQ-1:0]             req_save_cond_i,
  output logic [64:0]                    data_o,
  output logic [3:0]                     flags_o,
  output logic [ROBsizeLog-1:0]          tag_o,
  output logic                           save_cond_o,
  output logic [NUM_REQ-1:0]             grant_o
);

  localparam int PTR_W = $clog2(NUM_REQ);

  // Holding buffers
  logic [NUM_REQ-1:0]                 full_q, full_d;
  logic [NUM_REQ-1:0][63:0]           buf_data_q, buf_data_d;
  logic [NUM_REQ-1:0][3:0]            buf_flags_q, buf_flags_d;
  logic [NUM_REQ-1:0][ROBsizeLog-1:0] buf_tag_q, buf_tag_d;
  logic [NUM_REQ-1:0]                 buf_save_q, buf_save_d;

  // Output register
  logic [64:0]           data_q, data_d;
  logic [3:0]            flags_q, flags_d;
  logic [ROBsizeLog-1:0] tag_q, tag_d;
  logic                  save_q, save_d;

  logic             gnt_found;
  logic [PTR_W-1:0] gnt_idx;
  logic             kill;

  assign kill = flush_i | reset_i;

`ifdef COMPLETION_ARB_RR_EN
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W:0]   cand;

  // Scan starting at rr_ptr, wrapping; one extra bit holds the unwrapped sum.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(off);
      if (cand >= (PTR_W+1)'(NUM_REQ)) cand = cand - (PTR_W+1)'(NUM_REQ);
      if (!gnt_found && full_q[cand[PTR_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (|grant_o) begin
      rr_ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) rr_ptr_q <= '0;
    else         rr_ptr_q <= rr_ptr_d;
  end
`else
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_found && full_q[k]) begin
        gnt_found = 1'b1;
        gnt_idx   = PTR_W'(k);
      end
    end
  end
`endif

  // Grant depends only on full bits, so ready never depends on valid.
  always_comb begin
    grant_o = '0;
    if (gnt_found && !kill) grant_o[gnt_idx] = 1'b1;
  end

  // A draining buffer can take a new entry in the same cycle.
  assign req_ready_o = ~full_q | grant_o;

  always_comb begin
    full_d      = full_q & ~grant_o;
    buf_data_d  = buf_data_q;
    buf_flags_d = buf_flags_q;
    buf_tag_d   = buf_tag_q;
    buf_save_d  = buf_save_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      // Tag 0 handshakes but carries no instruction, so nothing is stored.
      if (req_valid_i[i] && req_ready_o[i] &&
          (req_tag_i[i*ROBsizeLog +: ROBsizeLog] != '0)) begin
        full_d[i]      = 1'b1;
        buf_data_d[i]  = req_data_i[i*64 +: 64];
        buf_flags_d[i] = req_flags_i[i*4 +: 4];
        buf_tag_d[i]   = req_tag_i[i*ROBsizeLog +: ROBsizeLog];
        buf_save_d[i]  = req_save_cond_i[i];
      end
    end
    if (flush_i) full_d = '0;
  end

  // Idle cycles clear valid and tag but keep the last payload.
  always_comb begin
    data_d  = {1'b0, data_q[63:0]};
    flags_d = flags_q;
    tag_d   = '0;
    save_d  = save_q;
    if (|grant_o) begin
      data_d  = {1'b1, buf_data_q[gnt_idx]};
      flags_d = buf_flags_q[gnt_idx];
      tag_d   = buf_tag_q[gnt_idx];
      save_d  = buf_save_q[gnt_idx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      full_q  <= '0;
      data_q  <= '0;
      flags_q <= '0;
      tag_q   <= '0;
      save_q  <= 1'b0;
    end else begin
      full_q  <= full_d;
      data_q  <= data_d;
      flags_q <= flags_d;
      tag_q   <= tag_d;
      save_q  <= save_d;
    end
  end

  // Payload is qualified by full_q, so it needs no reset.
  always_ff @(posedge clk_i) begin
    buf_data_q  <= buf_data_d;
    buf_flags_q <= buf_flags_d;
    buf_tag_q   <= buf_tag_d;
    buf_save_q  <= buf_save_d;
  end

  assign data_o      = data_q;
  assign flags_o     = flags_q;
  assign tag_o       = tag_q;
  assign save_cond_o = save_q;

endmodule

// File: tb/tb_completion_arbiter.sv
module tb_completion_arbiter;
  localparam int N  = 3;
  localparam int TW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_i, flush_i;
  logic [N-1:0]    req_valid_i, req_ready_o, req_save_cond_i, grant_o;
  logic [N*64-1:0] req_data_i;
  logic [N*4-1:0]  req_flags_i;
  logic [N*TW-1:0] req_tag_i;
  logic [64:0]     data_o;
  logic [3:0]      flags_o;
  logic [TW-1:0]   tag_o;
  logic            save_cond_o;

  completion_arbiter #(.NUM_REQ(N), .ROBsize(32)) dut (
    .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_data_i(req_data_i), .req_flags_i(req_flags_i),
    .req_tag_i(req_tag_i), .req_save_cond_i(req_save_cond_i),
    .data_o(data_o), .flags_o(flags_o), .tag_o(tag_o),
    .save_cond_o(save_cond_o), .grant_o(grant_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: buffers as arrays, winner chosen by a modular scan.
  logic [N-1:0]  m_full;
  logic [63:0]   m_data  [N];
  logic [3:0]    m_flags [N];
  logic [TW-1:0] m_tag   [N];
  logic          m_save  [N];
  int            m_rr;
  int            m_win;
  logic [N-1:0]  m_gnt, m_rdy;
  logic [64:0]   m_odata;
  logic [3:0]    m_oflags;
  logic [TW-1:0] m_otag;
  logic          m_osave;

  function automatic logic [75:0] m_bus();
    return {m_odata, m_oflags, m_otag, m_osave};
  endfunction

  task automatic model_comb();
    m_win = -1;
    if (!flush_i && !reset_i) begin
      for (int k = 0; k < N; k++) begin
`ifdef COMPLETION_ARB_RR_EN
        if (m_win < 0 && m_full[(m_rr + k) % N]) m_win = (m_rr + k) % N;
`else
        if (m_win < 0 && m_full[k]) m_win = k;
`endif
      end
    end
    m_gnt = '0;
    if (m_win >= 0) m_gnt[m_win] = 1'b1;
    for (int i = 0; i < N; i++) m_rdy[i] = !m_full[i] || m_gnt[i];
  endtask

  task automatic model_edge();
    if (reset_i) begin
      m_full = '0; m_rr = 0;
      m_odata = '0; m_oflags = '0; m_otag = '0; m_osave = 1'b0;
    end else if (flush_i) begin
      m_full = '0; m_odata[64] = 1'b0; m_otag = '0;
    end else begin
      if (m_win >= 0) begin
        m_odata  = {1'b1, m_data[m_win]};
        m_oflags = m_flags[m_win];
        m_otag   = m_tag[m_win];
        m_osave  = m_save[m_win];
        m_full[m_win] = 1'b0;
        m_rr = (m_win + 1) % N;
      end else begin
        m_odata[64] = 1'b0; m_otag = '0;
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid_i[i] && m_rdy[i] && req_tag_i[i*TW +: TW] != '0) begin
          m_full[i]  = 1'b1;
          m_data[i]  = req_data_i[i*64 +: 64];
          m_flags[i] = req_flags_i[i*4 +: 4];
          m_tag[i]   = req_tag_i[i*TW +: TW];
          m_save[i]  = req_save_cond_i[i];
        end
      end
    end
  endtask

  // One clock: model sees the same inputs the DUT samples; returns 1ns after the edge.
  task automatic tick();
    model_comb();
    @(posedge clk);
    model_edge();
    #1;
    model_comb();
  endtask

  task automatic set_req(input int i, input logic v, input logic [63:0] d,
                         input logic [3:0] f, input logic [TW-1:0] t, input logic s);
    req_valid_i[i]            = v;
    req_data_i[i*64 +: 64]    = d;
    req_flags_i[i*4 +: 4]     = f;
    req_tag_i[i*TW +: TW]     = t;
    req_save_cond_i[i]        = s;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; flush_i = 1'b0;
    req_valid_i = '0; req_data_i = '0; req_flags_i = '0; req_tag_i = '0; req_save_cond_i = '0;
    tick(); tick();
    reset_i = 1'b0;
    n_checks++;
    if ({flags_o, save_cond_o} !== 5'h0) $display("FAIL reset_flags_save got %h required 0", {flags_o, save_cond_o});
    else n_pass++;
    for (int c = 0; c < 10; c++) begin
      n_checks++;
      if ({data_o, tag_o, req_ready_o, grant_o} !== {65'h0, 6'h0, 3'b111, 3'b000})
        $display("FAIL reset_idle cyc %0d data=%h tag=%0d rdy=%b gnt=%b required 0/0/111/000",
                 c, data_o, tag_o, req_ready_o, grant_o);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_single();
    set_req(1, 1'b1, 64'hDEAD_BEEF, 4'hA, 6'd5, 1'b1);
    tick();
    set_req(1, 1'b0, '0, '0, '0, 1'b0);
    n_checks++;
    if (data_o[64] !== 1'b0) $display("FAIL single_early valid=%b required 0", data_o[64]);
    else n_pass++;
    tick();
    n_checks++;
    if ({data_o, flags_o, tag_o, save_cond_o} !== {1'b1, 64'hDEAD_BEEF, 4'hA, 6'd5, 1'b1})
      $display("FAIL single_out data=%h flags=%h tag=%0d save=%b required 1DEADBEEF/A/5/1",
               data_o, flags_o, tag_o, save_cond_o);
    else n_pass++;
    tick();
    n_checks++;
    if ({data_o, flags_o, tag_o} !== {1'b0, 64'hDEAD_BEEF, 4'hA, 6'd0})
      $display("FAIL single_idle data=%h flags=%h tag=%0d required 0DEADBEEF/A/0", data_o, flags_o, tag_o);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [TW-1:0] exp_tag;
    logic [N-1:0]  exp_gnt;
    reset_i = 1'b1; tick(); reset_i = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 64'h100 + 64'(i), 4'(i), TW'(i + 1), 1'b0);
    for (int t = 1; t <= 9; t++) begin
      tick();
`ifdef COMPLETION_ARB_RR_EN
      exp_gnt = N'(1) << ((t - 1) % N);
      exp_tag = TW'(((t - 2) % N) + 1);
`else
      exp_gnt = 3'b001;
      exp_tag = 6'd1;
`endif
      n_checks++;
      if (grant_o !== exp_gnt || req_ready_o !== exp_gnt)
        $display("FAIL rr_grant t=%0d gnt=%b rdy=%b required %b", t, grant_o, req_ready_o, exp_gnt);
      else n_pass++;
      if (t >= 2) begin
        n_checks++;
        if (tag_o !== exp_tag || data_o[64] !== 1'b1)
          $display("FAIL rr_tag t=%0d tag=%0d vld=%b required %0d/1", t, tag_o, data_o[64], exp_tag);
        else n_pass++;
      end
    end
    req_valid_i = '0;
    for (int c = 0; c < 5; c++) tick();
  endtask

  task automatic test_tag_zero();
    set_req(0, 1'b1, 64'h1234, 4'h3, 6'd0, 1'b1);
    n_checks++;
    if (req_ready_o[0] !== 1'b1) $display("FAIL tag0_ready got %b required 1", req_ready_o[0]);
    else n_pass++;
    tick();
    set_req(0, 1'b0, '0, '0, '0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (grant_o !== 3'b000 || data_o[64] !== 1'b0)
        $display("FAIL tag0_idle cyc %0d gnt=%b vld=%b required 000/0", c, grant_o, data_o[64]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 64'hF0 + 64'(i), 4'h1, TW'(i + 1), 1'b1);
    tick();
    req_valid_i = 3'b100;
    set_req(2, 1'b1, 64'hBAD, 4'hF, 6'd7, 1'b0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0; req_valid_i = '0;
    n_checks++;
    if ({data_o[64], tag_o, req_ready_o, grant_o} !== {1'b0, 6'd0, 3'b111, 3'b000})
      $display("FAIL flush_state vld=%b tag=%0d rdy=%b gnt=%b required 0/0/111/000",
               data_o[64], tag_o, req_ready_o, grant_o);
    else n_pass++;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (data_o[64] !== 1'b0 || tag_o !== 6'd0)
        $display("FAIL flush_after cyc %0d vld=%b tag=%0d required 0/0", c, data_o[64], tag_o);
      else n_pass++;
    end
  endtask

  task automatic test_reset_over_flush();
    set_req(0, 1'b1, 64'h55, 4'h5, 6'd4, 1'b0);
    tick();
    req_valid_i = '0;
    tick();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 64'hA0 + 64'(i), 4'h2, TW'(i + 1), 1'b1);
    tick();
    req_valid_i = '0;
    reset_i = 1'b1; flush_i = 1'b1;
    tick();
    reset_i = 1'b0; flush_i = 1'b0;
    n_checks++;
    if ({data_o, flags_o, tag_o, save_cond_o, req_ready_o, grant_o} !== {76'h0, 3'b111, 3'b000})
      $display("FAIL rst_flush_out data=%h flags=%h tag=%0d save=%b rdy=%b gnt=%b required all 0/111/000",
               data_o, flags_o, tag_o, save_cond_o, req_ready_o, grant_o);
    else n_pass++;
    req_valid_i = 3'b111;
    tick();
    req_valid_i = '0;
    n_checks++;
    if (grant_o !== 3'b001) $display("FAIL rst_flush_grant got %b required 001", grant_o);
    else n_pass++;
    tick();
    n_checks++;
    if (tag_o !== 6'd1) $display("FAIL rst_flush_tag got %0d required 1", tag_o);
    else n_pass++;
    for (int c = 0; c < 4; c++) tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset_i = ($urandom_range(0, 63) == 0);
      flush_i = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < N; i++)
        set_req(i, 1'($urandom_range(0, 1)), {$urandom, $urandom}, 4'($urandom),
                ($urandom_range(0, 4) == 0) ? 6'd0 : TW'($urandom_range(1, 32)),
                1'($urandom_range(0, 1)));
      tick();
      n_checks++;
      if ({data_o, flags_o, tag_o, save_cond_o} !== m_bus())
        $display("FAIL rand_out cyc %0d got %h required %h", c,
                 {data_o, flags_o, tag_o, save_cond_o}, m_bus());
      else n_pass++;
      n_checks++;
      if (grant_o !== m_gnt || req_ready_o !== m_rdy)
        $display("FAIL rand_hs cyc %0d gnt=%b rdy=%b required %b/%b", c, grant_o, req_ready_o, m_gnt, m_rdy);
      else n_pass++;
    end
    reset_i = 1'b0; flush_i = 1'b0; req_valid_i = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_tag_zero();
    test_flush();
    test_reset_over_flush();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
